// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: FSM states, opcodes and
// the framing/response byte constants.
package uart_cmd_decoder_pkg;

    // Decoder FSM states
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCmd    = 3'd1,
        StDataHi = 3'd2,
        StDataLo = 3'd3,
        StChk    = 3'd4,
        StResp   = 3'd5
    } state_e;

    // Opcodes carried in cmd[7:4]
    localparam logic [3:0] OpWriteReg = 4'h1;
    localparam logic [3:0] OpStart    = 4'h2;
    localparam logic [3:0] OpClear    = 4'h3;

    // Framing and response bytes
    localparam logic [7:0] SyncByte = 8'hA5;
    localparam logic [7:0] AckByte  = 8'h06;
    localparam logic [7:0] NakByte  = 8'h15;

    // True for opcodes the decoder knows how to execute
    function automatic logic opcode_known(input logic [3:0] op);
        return (op == OpWriteReg) || (op == OpStart) || (op == OpClear);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_timeout.sv
// Inter-byte timeout: counts cycles since the last kick while enabled and
// raises a one-cycle expired pulse after TIMEOUT_CYCLES quiet cycles.
module uart_byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    // A kick in the expiry cycle wins, so a late byte is never lost
    assign expired = enable && !kick && (cnt_q == CntMax);

    // Cycle counter, cleared when idle, on every byte and after expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!enable || kick || expired) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: frames A5/cmd/payload/checksum packets, executes
// register writes and start/clear commands, and answers with ACK or NAK.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NUM_REGS       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    output logic        reg_wr_en,
    output logic [3:0]  reg_addr,
    output logic [15:0] reg_wr_data,
    output logic        cmd_start,
    output logic        cmd_clear,
    output logic        pkt_error,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [3:0]  op_q;
    logic [3:0]  addr_q;
    logic        nak_q;
    logic [7:0]  chk_q;
    logic [7:0]  data_hi_q;
    logic [7:0]  data_lo_q;

    logic [7:0]  tx_data_q;
    logic        reg_wr_en_q;
    logic [3:0]  reg_addr_q;
    logic [15:0] reg_wr_data_q;
    logic        cmd_start_q;
    logic        cmd_clear_q;
    logic        pkt_error_q;

    logic        collecting;
    logic        tmo_expired;
    logic        cmd_nak;
    logic        cmd_is_write;
    logic        pkt_good;

    assign collecting   = (state_q == StCmd) || (state_q == StDataHi) ||
                          (state_q == StDataLo) || (state_q == StChk);
    assign cmd_is_write = (rx_data[7:4] == OpWriteReg);
    // Bad commands are still framed as zero-payload so the checksum byte is consumed
    assign cmd_nak      = !opcode_known(rx_data[7:4]) ||
                          (cmd_is_write && (32'(rx_data[3:0]) >= NUM_REGS));
    assign pkt_good     = (rx_data == chk_q) && !nak_q;

    uart_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_byte_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable (collecting),
        .kick   (rx_valid),
        .expired(tmo_expired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a byte always takes priority over timeout expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_valid && (rx_data == SyncByte)) state_d = StCmd;
            end
            StCmd: begin
                if (rx_valid) begin
                    state_d = (cmd_is_write && !cmd_nak) ? StDataHi : StChk;
                end else if (tmo_expired) begin
                    state_d = StIdle;
                end
            end
            StDataHi: begin
                if (rx_valid) state_d = StDataLo;
                else if (tmo_expired) state_d = StIdle;
            end
            StDataLo: begin
                if (rx_valid) state_d = StChk;
                else if (tmo_expired) state_d = StIdle;
            end
            StChk: begin
                if (rx_valid) state_d = StResp;
                else if (tmo_expired) state_d = StIdle;
            end
            StResp: begin
                if (tx_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: send in the first RESP cycle the transmitter is idle
    always_comb begin
        tx_send = (state_q == StResp) && tx_ready;
        busy    = (state_q != StIdle);
    end

    // Packet capture, action strobes and response byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            addr_q        <= '0;
            nak_q         <= 1'b0;
            chk_q         <= '0;
            data_hi_q     <= '0;
            data_lo_q     <= '0;
            tx_data_q     <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            cmd_start_q   <= 1'b0;
            cmd_clear_q   <= 1'b0;
            pkt_error_q   <= 1'b0;
        end else begin
            reg_wr_en_q <= 1'b0;
            cmd_start_q <= 1'b0;
            cmd_clear_q <= 1'b0;
            pkt_error_q <= collecting && tmo_expired;

            if (rx_valid) begin
                unique case (state_q)
                    StCmd: begin
                        op_q   <= rx_data[7:4];
                        addr_q <= rx_data[3:0];
                        nak_q  <= cmd_nak;
                        chk_q  <= rx_data;
                    end
                    StDataHi: begin
                        data_hi_q <= rx_data;
                        chk_q     <= chk_q ^ rx_data;
                    end
                    StDataLo: begin
                        data_lo_q <= rx_data;
                        chk_q     <= chk_q ^ rx_data;
                    end
                    StChk: begin
                        if (pkt_good) begin
                            tx_data_q <= AckByte;
                            if (op_q == OpWriteReg) begin
                                reg_wr_en_q   <= 1'b1;
                                reg_addr_q    <= addr_q;
                                reg_wr_data_q <= {data_hi_q, data_lo_q};
                            end
                            cmd_start_q <= (op_q == OpStart);
                            cmd_clear_q <= (op_q == OpClear);
                        end else begin
                            tx_data_q   <= NakByte;
                            pkt_error_q <= 1'b1;
                        end
                    end
                    // Bytes arriving while the response is pending are dropped
                    StResp: pkt_error_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign reg_wr_en   = reg_wr_en_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign cmd_start   = cmd_start_q;
    assign cmd_clear   = cmd_clear_q;
    assign pkt_error   = pkt_error_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed packets, timeout,
// back-pressure, mid-packet reset and randomized packets against a model.
module tb_uart_cmd_decoder;

    localparam int unsigned Tmo = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        reg_wr_en;
    logic [3:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic        cmd_start;
    logic        cmd_clear;
    logic        pkt_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Running totals of observed pulses, written only by the monitor
    int n_wr = 0, n_start = 0, n_clear = 0, n_err = 0, n_send = 0;
    logic [7:0] last_tx = 8'h00;

    // Expected holding values of reg_addr / reg_wr_data
    logic [3:0]  exp_addr_hold = 4'h0;
    logic [15:0] exp_data_hold = 16'h0;

    logic [7:0] pkt_q[$];

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES(Tmo),
        .NUM_REGS      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .reg_wr_en  (reg_wr_en),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .cmd_start  (cmd_start),
        .cmd_clear  (cmd_clear),
        .pkt_error  (pkt_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr_en) n_wr = n_wr + 1;
        if (cmd_start) n_start = n_start + 1;
        if (cmd_clear) n_clear = n_clear + 1;
        if (pkt_error) n_err = n_err + 1;
        if (tx_send) begin
            n_send  = n_send + 1;
            last_tx = tx_data;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
    endtask

    // Reference: parse pkt_q as a packet and derive the expected outcome.
    // kind: 0 none, 1 register write, 2 start, 3 clear
    task automatic model_packet(output int kind, output logic [3:0] addr,
                                output logic [15:0] data, output logic [7:0] resp,
                                output int errs);
        int i;
        int n;
        logic [7:0] cmd;
        logic [7:0] x;
        logic [3:0] op;
        logic known;
        i = 0;
        while (i < pkt_q.size() && pkt_q[i] != 8'hA5) i++;
        cmd   = pkt_q[i+1];
        op    = cmd[7:4];
        known = (op == 4'h1) || (op == 4'h2) || (op == 4'h3);
        n     = (op == 4'h1) ? 2 : 0;
        x     = cmd;
        for (int j = 0; j < n; j++) x = x ^ pkt_q[i+2+j];
        addr = cmd[3:0];
        data = (n == 2) ? {pkt_q[i+2], pkt_q[i+3]} : 16'h0000;
        if (known && x == pkt_q[i+2+n]) begin
            kind = int'(op);
            resp = 8'h06;
            errs = 0;
        end else begin
            kind = 0;
            resp = 8'h15;
            errs = 1;
        end
    endtask

    // Send pkt_q with random inter-byte gaps, hold tx_ready low for rd cycles
    // after the checksum, and check action timing, response and pulse counts.
    task automatic run_packet(input string name, input int rd);
        int kind, errs;
        int wr0, st0, cl0, er0, sd0;
        logic [3:0] a;
        logic [15:0] d;
        logic [7:0] resp;
        model_packet(kind, a, d, resp, errs);
        wr0 = n_wr; st0 = n_start; cl0 = n_clear; er0 = n_err; sd0 = n_send;
        tx_ready = (rd == 0);
        for (int i = 0; i < pkt_q.size(); i++) begin
            send_byte(pkt_q[i]);
            if (i != pkt_q.size() - 1) step($urandom_range(0, 3));
        end
        // One cycle after the checksum byte
        checks++;
        if ({reg_wr_en, cmd_start, cmd_clear, pkt_error} !==
            {kind == 1, kind == 2, kind == 3, errs == 1}) begin
            errors++;
            $display("FAIL %s action: wr/start/clear/err=%b expected %b", name,
                     {reg_wr_en, cmd_start, cmd_clear, pkt_error},
                     {kind == 1, kind == 2, kind == 3, errs == 1});
        end
        if (kind == 1) begin
            exp_addr_hold = a;
            exp_data_hold = d;
        end
        checks++;
        if (reg_addr !== exp_addr_hold || reg_wr_data !== exp_data_hold) begin
            errors++;
            $display("FAIL %s reg_out: addr=%h data=%h expected addr=%h data=%h", name,
                     reg_addr, reg_wr_data, exp_addr_hold, exp_data_hold);
        end
        step(rd);
        tx_ready = 1'b1;
        for (int k = 0; k < 20 && busy; k++) step(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b expected 0", name, busy);
        end
        step(1);
        checks++;
        if (n_send - sd0 != 1 || last_tx !== resp) begin
            errors++;
            $display("FAIL %s resp: sends=%0d tx=%h expected 1 send tx=%h", name,
                     n_send - sd0, last_tx, resp);
        end
        checks++;
        if (n_wr - wr0 != int'(kind == 1) || n_start - st0 != int'(kind == 2) ||
            n_clear - cl0 != int'(kind == 3) || n_err - er0 != errs) begin
            errors++;
            $display("FAIL %s counts: wr=%0d st=%0d cl=%0d err=%0d expected kind=%0d err=%0d",
                     name, n_wr - wr0, n_start - st0, n_clear - cl0, n_err - er0, kind, errs);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({tx_data, tx_send, reg_wr_en, reg_addr, reg_wr_data, cmd_start, cmd_clear,
             pkt_error, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero tx=%h addr=%h data=%h busy=%b",
                     tx_data, reg_addr, reg_wr_data, busy);
        end
        step(2);
        rst = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b0 || tx_send !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b tx_send=%b expected 0 0", busy, tx_send);
        end
    endtask

    task automatic test_directed();
        pkt_q = '{8'hA5, 8'h13, 8'h12, 8'h34, 8'h35};
        run_packet("write_reg", 0);
        pkt_q = '{8'h00, 8'h55, 8'hA5, 8'h20, 8'h20};
        run_packet("start", 0);
        pkt_q = '{8'hA5, 8'h30, 8'h30};
        run_packet("clear", 0);
        pkt_q = '{8'hA5, 8'h20, 8'h21};
        run_packet("bad_checksum", 0);
        pkt_q = '{8'hA5, 8'h70, 8'h70};
        run_packet("bad_opcode", 0);
        // A5 inside the payload is data, not a resync
        pkt_q = '{8'hA5, 8'h1F, 8'hA5, 8'hA5, 8'h1F};
        run_packet("a5_payload", 0);
    endtask

    task automatic test_timeout();
        int er0, sd0;
        er0 = n_err; sd0 = n_send;
        send_byte(8'hA5);
        send_byte(8'h13);
        step(Tmo - 1);
        checks++;
        if (busy !== 1'b1 || n_err != er0) begin
            errors++;
            $display("FAIL timeout_early: busy=%b errs=%0d expected 1 0", busy, n_err - er0);
        end
        step(1);
        checks++;
        if (busy !== 1'b0 || pkt_error !== 1'b1 || n_send != sd0) begin
            errors++;
            $display("FAIL timeout_expire: busy=%b pkt_error=%b sends=%0d expected 0 1 0",
                     busy, pkt_error, n_send - sd0);
        end
        step(2);
        pkt_q = '{8'hA5, 8'h20, 8'h20};
        run_packet("after_timeout", 0);
        // Byte landing on the expiry cycle wins
        er0 = n_err;
        send_byte(8'hA5);
        send_byte(8'h13);
        step(Tmo - 1);
        send_byte(8'h12);
        checks++;
        if (busy !== 1'b1 || n_err != er0) begin
            errors++;
            $display("FAIL timeout_race: busy=%b errs=%0d expected 1 0", busy, n_err - er0);
        end
        pkt_q = '{8'h34, 8'h35};
        pkt_q.push_front(8'h12);
        pkt_q.push_front(8'h13);
        pkt_q.push_front(8'hA5);
        // Finish the packet: only the last two bytes remain to be sent
        send_byte(8'h34);
        send_byte(8'h35);
        checks++;
        if (reg_wr_en !== 1'b1 || reg_wr_data !== 16'h1234 || reg_addr !== 4'h3) begin
            errors++;
            $display("FAIL timeout_race_write: wr=%b addr=%h data=%h expected 1 3 1234",
                     reg_wr_en, reg_addr, reg_wr_data);
        end
        exp_addr_hold = 4'h3;
        exp_data_hold = 16'h1234;
        step(3);
    endtask

    task automatic test_backpressure();
        int sd0, er0;
        logic stable;
        sd0 = n_send; er0 = n_err;
        tx_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h20);
        stable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (k == 10) send_byte(8'h77);
            else step(1);
            if (tx_data !== 8'h06 || busy !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (n_send != sd0 || !stable) begin
            errors++;
            $display("FAIL backpressure_hold: sends=%0d stable=%b expected 0 1",
                     n_send - sd0, stable);
        end
        checks++;
        if (n_err - er0 != 1) begin
            errors++;
            $display("FAIL resp_drop: pkt_errors=%0d expected 1", n_err - er0);
        end
        tx_ready = 1'b1;
        step(5);
        checks++;
        if (n_send - sd0 != 1 || last_tx !== 8'h06 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: sends=%0d tx=%h busy=%b expected 1 06 0",
                     n_send - sd0, last_tx, busy);
        end
    endtask

    task automatic test_reset_mid();
        int wr0, sd0;
        wr0 = n_wr; sd0 = n_send;
        send_byte(8'hA5);
        send_byte(8'h13);
        send_byte(8'h12);
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_data, tx_send, reg_wr_en, reg_addr, reg_wr_data, cmd_start, cmd_clear,
             pkt_error, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: tx=%h addr=%h data=%h busy=%b expected all 0",
                     tx_data, reg_addr, reg_wr_data, busy);
        end
        step(2);
        rst = 1'b0;
        exp_addr_hold = 4'h0;
        exp_data_hold = 16'h0;
        send_byte(8'h34);
        send_byte(8'h35);
        step(10);
        checks++;
        if (n_wr != wr0 || n_send != sd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: writes=%0d sends=%0d busy=%b expected 0 0 0",
                     n_wr - wr0, n_send - sd0, busy);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [7:0] cmd, hi, lo, x, junk;
        int sel;
        for (int t = 0; t < 40; t++) begin
            pkt_q.delete();
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                pkt_q.push_back(junk);
            end
            sel = $urandom_range(0, 5);
            if (sel <= 1) op = 4'h1;
            else if (sel == 2) op = 4'h2;
            else if (sel == 3) op = 4'h3;
            else if (sel == 4) op = 4'h0;
            else op = 4'($urandom_range(4, 15));
            cmd = {op, 4'($urandom)};
            pkt_q.push_back(8'hA5);
            pkt_q.push_back(cmd);
            x = cmd;
            if (op == 4'h1) begin
                hi = 8'($urandom);
                lo = 8'($urandom);
                pkt_q.push_back(hi);
                pkt_q.push_back(lo);
                x = x ^ hi ^ lo;
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            pkt_q.push_back(x);
            run_packet("random", $urandom_range(0, 5));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
